// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath constants (register file geometry, register indices, write-back select codes)
package cpu_pkg;
   localparam int REG_W = 32;
   localparam int REG_N = 32;
   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_GP = 5'd28;
   localparam logic [4:0] REG_SP = 5'd29;
   localparam logic [4:0] REG_RA = 5'd31;
   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;
endpackage

// File: rtl/gpr_file.sv
// gpr_file: 32x32 register file, two async read ports, one sync write port, write scoreboard
// GPR_BYPASS_EN: forward the in-flight write-back word to matching read ports
module gpr_file
   import cpu_pkg::*;
#(
   parameter logic [REG_W-1:0] SP_INIT = 32'h0000_2FFC,
   parameter logic [REG_W-1:0] GP_INIT = 32'h0000_1800,
   parameter logic [4:0] LINK_REG = REG_RA
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       rd_addr_a,
   input  logic [4:0]       rd_addr_b,
   output logic [REG_W-1:0] rd_data_a,
   output logic [REG_W-1:0] rd_data_b,
   input  logic             wr_en,
   input  logic             wr_link,
   input  logic [4:0]       wr_addr,
   input  logic [REG_W-1:0] wr_data,
   output logic             wr_ack,
   output logic [REG_N-1:0] dirty_mask
);
   logic [REG_W-1:0] regs [REG_N];
   logic [4:0] dest;
   logic we;
   logic [4:0] ra [2];
   logic [REG_W-1:0] rv [2];
   assign dest = wr_link ? LINK_REG : wr_addr;
   assign we = wr_en && (dest != REG_ZERO);
   // reg 0 is never written, so it keeps its reset value of zero
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < REG_N; i++) regs[i] <= '0;
         regs[REG_GP] <= GP_INIT;
         regs[REG_SP] <= SP_INIT;
         dirty_mask <= '0;
         wr_ack <= 1'b0;
      end else if (we) begin
         regs[dest] <= wr_data;
         dirty_mask[dest] <= 1'b1;
         wr_ack <= 1'b1;
      end else
         wr_ack <= 1'b0;
   assign ra[0] = rd_addr_a;
   assign ra[1] = rd_addr_b;
   for (genvar p = 0; p < 2; p++) begin : g_rd
`ifdef GPR_BYPASS_EN
      assign rv[p] = (we && ra[p] == dest) ? wr_data : regs[ra[p]];
`else
      assign rv[p] = regs[ra[p]];
`endif
   end
   assign rd_data_a = rv[0];
   assign rd_data_b = rv[1];
   a_wr_en_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(wr_en));
endmodule

// File: tb/tb_gpr_file.sv
// tb_gpr_file: randomized self-checking bench for gpr_file against an array-based reference model
module tb_gpr_file;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [4:0] rd_addr_a = '0, rd_addr_b = '0, wr_addr = '0;
   logic [31:0] rd_data_a, rd_data_b, wr_data = '0;
   logic wr_en = 1'b0, wr_link = 1'b0;
   logic wr_ack;
   logic [31:0] dirty_mask;
   int vectors = 0;
   int errors = 0;
   logic [31:0] mem [32];
   logic [31:0] m_dirty;
   logic m_ack;
   gpr_file dut (
      .clk(clk), .rst_n(rst_n),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .wr_en(wr_en), .wr_link(wr_link), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ack(wr_ack), .dirty_mask(dirty_mask)
   );
   always #5 clk = ~clk;
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
   task automatic model_reset();
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      mem[28] = 32'h0000_1800;
      mem[29] = 32'h0000_2FFC;
      m_dirty = '0;
      m_ack = 1'b0;
   endtask
   function automatic logic [4:0] m_dest();
      return wr_link ? 5'd31 : wr_addr;
   endfunction
   // value a read port must show before the pending write commits
   function automatic logic [31:0] m_read(input logic [4:0] a);
`ifdef GPR_BYPASS_EN
      if (wr_en && m_dest() != 5'd0 && a == m_dest()) return wr_data;
`endif
      return mem[a];
   endfunction
   task automatic tick();
      logic [4:0] d;
      @(posedge clk);
      d = m_dest();
      m_ack = wr_en && d != 5'd0;
      if (m_ack) begin
         mem[d] = wr_data;
         m_dirty[d] = 1'b1;
      end
      #1;
   endtask
   task automatic idle();
      wr_en = 1'b0;
      wr_link = 1'b0;
      #1;
   endtask
   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      model_reset();
      for (int a = 0; a < 32; a++) begin
         rd_addr_a = 5'(a);
         rd_addr_b = 5'(31 - a);
         #1;
         vectors++;
         if (rd_data_a !== mem[a] || rd_data_b !== mem[31 - a]) begin
            errors++;
            $display("FAIL reset_read a=%0d: got %h/%h expected %h/%h", a, rd_data_a, rd_data_b, mem[a], mem[31 - a]);
         end
      end
      vectors++;
      if (dirty_mask !== 32'h0 || wr_ack !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: dirty=%h ack=%b expected 0/0", dirty_mask, wr_ack);
      end
   endtask
   task automatic test_write_read();
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
      rd_addr_a = 5'd5; rd_addr_b = 5'd5;
      #1;
      vectors++;
`ifdef GPR_BYPASS_EN
      if (rd_data_a !== 32'hDEAD_BEEF) begin
`else
      if (rd_data_a !== 32'h0) begin
`endif
         errors++;
         $display("FAIL write_same_cycle: got %h", rd_data_a);
      end
      tick();
      idle();
      vectors++;
      if (rd_data_a !== 32'hDEAD_BEEF || wr_ack !== 1'b1 || dirty_mask[5] !== 1'b1) begin
         errors++;
         $display("FAIL write_next_cycle: data=%h ack=%b dirty5=%b expected deadbeef/1/1", rd_data_a, wr_ack, dirty_mask[5]);
      end
   endtask
   task automatic test_zero();
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
      rd_addr_a = 5'd0; rd_addr_b = 5'd0;
      #1;
      vectors++;
      if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0) begin
         errors++;
         $display("FAIL zero_same_cycle: got %h/%h expected 0", rd_data_a, rd_data_b);
      end
      tick();
      idle();
      vectors++;
      if (rd_data_a !== 32'h0 || wr_ack !== 1'b0 || dirty_mask[0] !== 1'b0 || dirty_mask !== m_dirty) begin
         errors++;
         $display("FAIL zero_reg: data=%h ack=%b dirty=%h expected 0/0/%h", rd_data_a, wr_ack, dirty_mask, m_dirty);
      end
   endtask
   task automatic test_link();
      @(negedge clk);
      wr_en = 1'b1; wr_link = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_3008;
      tick();
      idle();
      rd_addr_a = 5'd31; rd_addr_b = 5'd7;
      #1;
      vectors++;
      if (rd_data_a !== 32'h0000_3008 || rd_data_b !== 32'h0 || wr_ack !== 1'b1 || dirty_mask !== m_dirty) begin
         errors++;
         $display("FAIL link: r31=%h r7=%h ack=%b dirty=%h expected 00003008/0/1/%h", rd_data_a, rd_data_b, wr_ack, dirty_mask, m_dirty);
      end
   endtask
   task automatic test_async_reset();
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1234_5678;
      #2;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wr_en = 1'b0;
      model_reset();
      rd_addr_a = 5'd9; rd_addr_b = 5'd29;
      #1;
      vectors++;
      if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0000_2FFC || dirty_mask !== 32'h0 || wr_ack !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: r9=%h r29=%h dirty=%h ack=%b expected 0/00002ffc/0/0", rd_data_a, rd_data_b, dirty_mask, wr_ack);
      end
   endtask
   task automatic test_same_cycle();
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'hA5A5_A5A5;
      rd_addr_a = 5'd12; rd_addr_b = 5'd12;
      #1;
      vectors++;
`ifdef GPR_BYPASS_EN
      if (rd_data_a !== 32'hA5A5_A5A5 || rd_data_b !== 32'hA5A5_A5A5) begin
`else
      if (rd_data_a !== mem[12] || rd_data_b !== rd_data_a) begin
`endif
         errors++;
         $display("FAIL same_cycle: got %h/%h", rd_data_a, rd_data_b);
      end
      tick();
      idle();
   endtask
   task automatic test_back_to_back();
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         wr_en = 1'b1; wr_addr = 5'(16 + k); wr_data = $urandom;
         tick();
         vectors++;
         if (wr_ack !== 1'b1 || dirty_mask !== m_dirty) begin
            errors++;
            $display("FAIL back_to_back k=%0d: ack=%b dirty=%h expected 1/%h", k, wr_ack, dirty_mask, m_dirty);
         end
      end
      idle();
   endtask
   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         wr_en = ($urandom % 4) != 0;
         wr_link = ($urandom % 8) == 0;
         wr_addr = 5'($urandom);
         wr_data = $urandom;
         rd_addr_a = ($urandom % 3 == 0) ? m_dest() : 5'($urandom);
         rd_addr_b = ($urandom % 3 == 0) ? m_dest() : 5'($urandom);
         #1;
         vectors++;
         if (rd_data_a !== m_read(rd_addr_a) || rd_data_b !== m_read(rd_addr_b)) begin
            errors++;
            $display("FAIL random_read n=%0d a=%0d b=%0d: got %h/%h expected %h/%h", n, rd_addr_a, rd_addr_b, rd_data_a, rd_data_b, m_read(rd_addr_a), m_read(rd_addr_b));
         end
         tick();
         vectors++;
         if (wr_ack !== m_ack || dirty_mask !== m_dirty) begin
            errors++;
            $display("FAIL random_commit n=%0d: ack=%b dirty=%h expected %b/%h", n, wr_ack, dirty_mask, m_ack, m_dirty);
         end
      end
      idle();
   endtask
   initial begin
      model_reset();
      #12;
      test_reset();
      test_write_read();
      test_zero();
      test_link();
      test_same_cycle();
      test_back_to_back();
      test_random();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
